// File: rtl/vscale_fetch_queue.sv
// Decoupled instruction-fetch front end: sequential imem prefetch into a DEPTH-entry queue
// of {pc, inst, badmem}, drained by decode through a valid/ready handshake.
module vscale_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0200
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_wait,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     imem_badmem_e,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic                     out_badmem,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            halt_q, halt_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic            bad_mem  [DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic [CW:0]   pending;

    // Credit counts the in-flight fetch so a response always has a free slot.
    assign pending   = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign imem_req  = !reset && !halt_q && (pending < (CW+1)'(DEPTH));
    assign imem_addr = redirect_valid ? redirect_pc : fetch_pc_q;
    assign accept    = imem_req && !imem_wait;

    // A redirect drops the response of the pre-redirect fetch and ignores any pop.
    assign push = inflight_q && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    assign out_valid  = (count_q != '0);
    assign out_pc     = pc_mem[head_q];
    assign out_inst   = inst_mem[head_q];
    assign out_badmem = bad_mem[head_q];
    assign occupancy  = count_q;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        halt_d        = halt_q;
        inflight_d    = accept;
        inflight_pc_d = imem_addr;
        if (accept) begin
            fetch_pc_d = imem_addr + XLEN'(4);
        end else if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            halt_d  = 1'b0;
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
                if (imem_badmem_e) begin
                    halt_d = 1'b1;
                end
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            halt_q        <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            halt_q        <= halt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= inflight_pc_q;
            inst_mem[tail_q] <= imem_rdata;
            bad_mem[tail_q]  <= imem_badmem_e;
        end
    end

endmodule
